// File: rtl/onewire_hex_fmt.sv
// Hex-dump formatter behind the 1-Wire master: buffers received bytes in a FIFO
// and streams them to the UART as two ASCII hex digits plus a separator or CR LF.
module onewire_hex_fmt #(
   parameter int FIFO_DEPTH     = 8,
   parameter int BYTES_PER_LINE = 8
) (
   input  logic       clk_10,
   input  logic       arst_n,
   input  logic [7:0] in_byte,
   input  logic       in_valid,
   input  logic       uart_tx_busy,
   output logic [7:0] uart_tx_data,
   output logic       uart_tx_write,
   output logic       fifo_full,
   output logic       overflow,
   input  logic       clear_ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [LW-1:0] LAST_COL = LW'(BYTES_PER_LINE - 1);

   typedef enum logic [2:0] {
      IDLE,
      HI,
      LO,
      SEP,
      CR,
      LF
   } state_t;

   logic [7:0]    fifoMem_q [FIFO_DEPTH];
   logic [AW-1:0] wrPtr_q;
   logic [AW-1:0] rdPtr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          fifoFull_q;
   logic          overflow_q;

   state_t        state_q;
   logic [7:0]    curByte_q;
   logic [LW-1:0] lineCnt_q;
   logic          holdoff_q;
   logic          txWrite_q;
   logic [7:0]    txData_q;

   logic          fifoEmpty;
   logic          fifoAtFull;
   logic          pop;
   logic          push;
   logic          drop;
   logic          isCharState;
   logic [7:0]    charOut;
   logic          fire;

   function automatic logic [7:0] hexChar(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h37 + {4'h0, nib};
   endfunction

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte then.
   always_comb begin
      fifoEmpty  = (count_q == '0);
      fifoAtFull = (count_q == FULL_CNT);
      pop        = (state_q == IDLE) && !fifoEmpty;
      push       = in_valid && (!fifoAtFull || pop);
      drop       = in_valid && fifoAtFull && !pop;
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_10) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= in_byte;
      end
   end

   // Pointers wrap naturally since the depth is a power of two; set beats clear on overflow.
   always_ff @(posedge clk_10 or negedge arst_n) begin
      if (!arst_n) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         fifoFull_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
         count_q    <= count_d;
         fifoFull_q <= (count_d == FULL_CNT);
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (clear_ovf) begin
            overflow_q <= 1'b0;
         end
      end
   end

   always_comb begin
      isCharState = 1'b1;
      charOut     = 8'h00;
      case (state_q)
         HI:      charOut = hexChar(curByte_q[7:4]);
         LO:      charOut = hexChar(curByte_q[3:0]);
         SEP:     charOut = 8'h20;
         CR:      charOut = 8'h0D;
         LF:      charOut = 8'h0A;
         default: isCharState = 1'b0;
      endcase
      fire = isCharState && !uart_tx_busy && !holdoff_q;
   end

   // Holdoff blocks the cycle right after a write, before the UART has raised busy.
   always_ff @(posedge clk_10 or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= IDLE;
         curByte_q <= 8'h00;
         lineCnt_q <= '0;
         holdoff_q <= 1'b0;
         txWrite_q <= 1'b0;
         txData_q  <= 8'h00;
      end else begin
         txWrite_q <= fire;
         holdoff_q <= fire;
         if (fire) begin
            txData_q <= charOut;
         end
         case (state_q)
            IDLE: begin
               if (pop) begin
                  curByte_q <= fifoMem_q[rdPtr_q];
                  state_q   <= HI;
               end
            end
            HI: begin
               if (fire) begin
                  state_q <= LO;
               end
            end
            LO: begin
               if (fire) begin
                  if (lineCnt_q == LAST_COL) begin
                     lineCnt_q <= '0;
                     state_q   <= CR;
                  end else begin
                     lineCnt_q <= lineCnt_q + LW'(1);
                     state_q   <= SEP;
                  end
               end
            end
            SEP: begin
               if (fire) begin
                  state_q <= IDLE;
               end
            end
            CR: begin
               if (fire) begin
                  state_q <= LF;
               end
            end
            LF: begin
               if (fire) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign uart_tx_data  = txData_q;
   assign uart_tx_write = txWrite_q;
   assign fifo_full     = fifoFull_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_onewire_hex_fmt.sv
// Directed bench for onewire_hex_fmt: captures every UART write and compares the
// character stream, timing, FIFO flags and reset behaviour against hand-built vectors.
module tb_onewire_hex_fmt;

   logic       clk_10 = 1'b0;
   logic       arst_n;
   logic [7:0] in_byte;
   logic       in_valid;
   logic       uart_tx_busy;
   logic [7:0] uart_tx_data;
   logic       uart_tx_write;
   logic       fifo_full;
   logic       overflow;
   logic       clear_ovf;

   logic       busyManual;
   logic       busyAuto;
   logic       busyAutoLevel = 1'b0;
   int         busyCnt = 0;
   int         busyViol = 0;

   int         cyc = 0;
   int         pushCyc = 0;
   int         errCnt = 0;
   int         chkCnt = 0;
   int         base = 0;

   logic [7:0] capQ [$];
   int         capT [$];
   logic [7:0] expQ [$];

   always #5 clk_10 = ~clk_10;

   assign uart_tx_busy = busyManual | busyAutoLevel;

   onewire_hex_fmt #(
      .FIFO_DEPTH     (8),
      .BYTES_PER_LINE (8)
   ) dut (
      .clk_10        (clk_10),
      .arst_n        (arst_n),
      .in_byte       (in_byte),
      .in_valid      (in_valid),
      .uart_tx_busy  (uart_tx_busy),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_write (uart_tx_write),
      .fifo_full     (fifo_full),
      .overflow      (overflow),
      .clear_ovf     (clear_ovf)
   );

   always @(posedge clk_10) begin
      cyc <= cyc + 1;
   end

   // Record every write on the falling edge; in auto mode emulate a UART that stays busy for 100 cycles.
   always @(negedge clk_10) begin
      if (uart_tx_write) begin
         if (busyAuto && uart_tx_busy) begin
            busyViol = busyViol + 1;
         end
         capQ.push_back(uart_tx_data);
         capT.push_back(cyc);
      end
      if (!busyAuto) begin
         busyAutoLevel = 1'b0;
         busyCnt       = 0;
      end else if (uart_tx_write) begin
         busyAutoLevel = 1'b1;
         busyCnt       = 100;
      end else if (busyCnt > 0) begin
         busyCnt = busyCnt - 1;
         if (busyCnt == 0) begin
            busyAutoLevel = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      chkCnt = chkCnt + 1;
      if (actual !== expected) begin
         errCnt = errCnt + 1;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic doReset();
      @(negedge clk_10);
      arst_n     = 1'b0;
      in_valid   = 1'b0;
      clear_ovf  = 1'b0;
      busyManual = 1'b0;
      repeat (2) @(negedge clk_10);
      arst_n = 1'b1;
      @(negedge clk_10);
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk_10);
      in_byte  = b;
      in_valid = 1'b1;
      pushCyc  = cyc;
      @(negedge clk_10);
      in_valid = 1'b0;
   endtask

   task automatic compareChars(input string name, input int startIdx, input int limit);
      int got;
      int t;
      t = 0;
      while (((capQ.size() - startIdx) < expQ.size()) && (t < limit)) begin
         @(negedge clk_10);
         t = t + 1;
      end
      repeat (20) @(negedge clk_10);
      got = capQ.size() - startIdx;
      checkOutput({name, "_count"}, got, expQ.size());
      for (int i = 0; (i < expQ.size()) && (i < got); i++) begin
         checkOutput($sformatf("%s_char%0d", name, i), {24'h0, capQ[startIdx + i]}, {24'h0, expQ[i]});
      end
   endtask

   initial begin
      int t;
      arst_n     = 1'b0;
      in_byte    = 8'h00;
      in_valid   = 1'b0;
      clear_ovf  = 1'b0;
      busyManual = 1'b0;
      busyAuto   = 1'b0;

      // Reset values
      repeat (2) @(negedge clk_10);
      checkOutput("rst_write", {31'h0, uart_tx_write}, 32'h0);
      checkOutput("rst_data", {24'h0, uart_tx_data}, 32'h0);
      checkOutput("rst_full", {31'h0, fifo_full}, 32'h0);
      checkOutput("rst_ovf", {31'h0, overflow}, 32'h0);
      arst_n = 1'b1;
      @(negedge clk_10);

      // Single byte: latency and pulse spacing
      base = capQ.size();
      applyStimulus(8'h41);
      expQ = {8'h34, 8'h31, 8'h20};
      compareChars("single", base, 100);
      if ((capQ.size() - base) >= 3) begin
         checkOutput("latency", capT[base], pushCyc + 3);
         checkOutput("spacing01", capT[base + 1] - capT[base], 2);
         checkOutput("spacing12", capT[base + 2] - capT[base + 1], 2);
      end else begin
         checkOutput("latency_samples", capQ.size() - base, 3);
      end
      checkOutput("data_hold", {24'h0, uart_tx_data}, 32'h20);

      // Hex letters
      doReset();
      base = capQ.size();
      applyStimulus(8'hAF);
      applyStimulus(8'h09);
      expQ = {8'h41, 8'h46, 8'h20, 8'h30, 8'h39, 8'h20};
      compareChars("letters", base, 200);

      // Line end after eight bytes, then a fresh line
      doReset();
      base = capQ.size();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'(i));
      end
      applyStimulus(8'h10);
      expQ.delete();
      for (int i = 0; i < 7; i++) begin
         expQ.push_back(8'h30);
         expQ.push_back(8'h30 + 8'(i));
         expQ.push_back(8'h20);
      end
      expQ.push_back(8'h30);
      expQ.push_back(8'h37);
      expQ.push_back(8'h0D);
      expQ.push_back(8'h0A);
      expQ.push_back(8'h31);
      expQ.push_back(8'h30);
      expQ.push_back(8'h20);
      compareChars("line", base, 500);
      checkOutput("line_ovf", {31'h0, overflow}, 32'h0);

      // Overflow with busy held: 0x55 parks in the formatter, then ten bytes hit the FIFO
      doReset();
      base = capQ.size();
      busyManual = 1'b1;
      applyStimulus(8'h55);
      repeat (3) @(negedge clk_10);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_10);
         if (i == 8) begin
            checkOutput("ovf_full8", {31'h0, fifo_full}, 32'h1);
            checkOutput("ovf_clear8", {31'h0, overflow}, 32'h0);
         end
         if (i == 9) begin
            checkOutput("ovf_set9", {31'h0, overflow}, 32'h1);
         end
         in_byte  = 8'h80 + 8'(i);
         in_valid = 1'b1;
      end
      @(negedge clk_10);
      in_valid = 1'b0;
      checkOutput("ovf_noWriteBusy", capQ.size() - base, 0);
      busyManual = 1'b0;
      expQ = {8'h35, 8'h35, 8'h20};
      for (int i = 0; i < 6; i++) begin
         expQ.push_back(8'h38);
         expQ.push_back(8'h30 + 8'(i));
         expQ.push_back(8'h20);
      end
      expQ.push_back(8'h38);
      expQ.push_back(8'h36);
      expQ.push_back(8'h0D);
      expQ.push_back(8'h0A);
      expQ.push_back(8'h38);
      expQ.push_back(8'h37);
      expQ.push_back(8'h20);
      compareChars("ovf", base, 600);
      checkOutput("ovf_sticky", {31'h0, overflow}, 32'h1);
      checkOutput("ovf_fullDrained", {31'h0, fifo_full}, 32'h0);
      @(negedge clk_10);
      clear_ovf = 1'b1;
      @(negedge clk_10);
      clear_ovf = 1'b0;
      checkOutput("ovf_cleared", {31'h0, overflow}, 32'h0);

      // Busy handshake: UART busy for 100 cycles after each write
      doReset();
      base = capQ.size();
      busyAuto = 1'b1;
      applyStimulus(8'h3C);
      applyStimulus(8'hD2);
      expQ = {8'h33, 8'h43, 8'h20, 8'h44, 8'h32, 8'h20};
      compareChars("busy", base, 3000);
      checkOutput("busy_violations", busyViol, 0);
      if ((capQ.size() - base) >= 2) begin
         checkOutput("busy_gap", (capT[base + 1] - capT[base]) > 100, 1);
      end
      busyAuto = 1'b0;
      repeat (110) @(negedge clk_10);

      // Reset in the middle of byte 0x5A with three bytes queued
      doReset();
      base = capQ.size();
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      expQ = {8'h30, 8'h31, 8'h20, 8'h30, 8'h32, 8'h20, 8'h30, 8'h33, 8'h20};
      compareChars("pre", base, 200);
      busyManual = 1'b1;
      applyStimulus(8'h5A);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      repeat (3) @(negedge clk_10);
      busyManual = 1'b0;
      t = 0;
      @(negedge clk_10);
      while (!uart_tx_write && (t < 50)) begin
         @(negedge clk_10);
         t = t + 1;
      end
      busyManual = 1'b1;
      checkOutput("mid_hiChar", {24'h0, uart_tx_data}, 32'h35);
      checkOutput("mid_writeHigh", {31'h0, uart_tx_write}, 32'h1);
      #1 arst_n = 1'b0;
      #1;
      checkOutput("mid_rstWrite", {31'h0, uart_tx_write}, 32'h0);
      checkOutput("mid_rstData", {24'h0, uart_tx_data}, 32'h0);
      checkOutput("mid_rstFull", {31'h0, fifo_full}, 32'h0);
      checkOutput("mid_rstOvf", {31'h0, overflow}, 32'h0);
      @(negedge clk_10);
      @(negedge clk_10);
      busyManual = 1'b0;
      arst_n     = 1'b1;
      @(negedge clk_10);
      base = capQ.size();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'h12 + 8'(i));
      end
      expQ.delete();
      for (int i = 0; i < 7; i++) begin
         expQ.push_back(8'h31);
         expQ.push_back(8'h32 + 8'(i));
         expQ.push_back(8'h20);
      end
      expQ.push_back(8'h31);
      expQ.push_back(8'h39);
      expQ.push_back(8'h0D);
      expQ.push_back(8'h0A);
      compareChars("post", base, 500);

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
